// File: rtl/ofdm_tx_pkg.sv
// Shared 802.11a L-SIG definitions: field widths, rate code table and rate lookup.
package ofdm_tx_pkg;

  localparam int unsigned SIG_BITS  = 24;
  localparam int unsigned RATE_BITS = 4;
  localparam int unsigned LEN_BITS  = 12;
  localparam int unsigned TAIL_BITS = 6;
  localparam int unsigned NUM_RATES = 8;

  localparam logic [5:0] RATE_MBPS [NUM_RATES] = '{
    6'd6, 6'd9, 6'd12, 6'd18, 6'd24, 6'd36, 6'd48, 6'd54
  };

  // Written with R1 in the MSB, so each literal reads left to right in transmit order.
  localparam logic [RATE_BITS-1:0] RATE_CODE [NUM_RATES] = '{
    4'b1101, 4'b1111, 4'b0101, 4'b0111, 4'b1001, 4'b1011, 4'b0001, 4'b0011
  };

  typedef struct packed {
    logic                 valid;
    logic [RATE_BITS-1:0] code;
  } rate_code_t;

  function automatic rate_code_t sig_rate_code(input logic [5:0] rate);
    rate_code_t rc;
    rc = '0;
    for (int i = 0; i < int'(NUM_RATES); i++) begin
      if (rate == RATE_MBPS[i]) begin
        rc.valid = 1'b1;
        rc.code  = RATE_CODE[i];
      end
    end
    return rc;
  endfunction

endpackage

// File: rtl/sig_serializer.sv
// Parallel-in shifter emitting OUT_W bits per beat, LSB first, over valid/ready.
module sig_serializer #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned OUT_W = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  output logic             valid,
  input  logic             ready,
  output logic [OUT_W-1:0] data,
  output logic             last,
  output logic             done
);

  localparam int unsigned BEATS = WIDTH / OUT_W;
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  logic [WIDTH-1:0] shift_q;
  logic [CNT_W-1:0] cnt_q;
  logic             valid_q;
  logic             last_q;
  logic             fire;

  assign fire = valid_q && ready;
  assign done = fire && last_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else if (load) begin
      shift_q <= load_data;
      cnt_q   <= '0;
      valid_q <= 1'b1;
      last_q  <= (BEATS == 1);
    end else if (fire) begin
      // Shifting out the final beat also leaves the data register cleared.
      shift_q <= shift_q >> OUT_W;
      if (last_q) begin
        cnt_q   <= '0;
        valid_q <= 1'b0;
        last_q  <= 1'b0;
      end else begin
        cnt_q  <= cnt_q + 1'b1;
        last_q <= ((cnt_q + 1'b1) == LAST_BEAT);
      end
    end
  end

  assign valid = valid_q;
  assign data  = shift_q[OUT_W-1:0];
  assign last  = last_q;

endmodule

// File: rtl/tx_sig_field_gen.sv
// 802.11a SIGNAL-field generator: validates a rate/length request, assembles the
// 24-bit L-SIG and streams it OUT_W bits per beat.
module tx_sig_field_gen
  import ofdm_tx_pkg::*;
#(
  parameter int unsigned OUT_W   = 1,
  parameter int unsigned MAX_LEN = 4095
) (
  input  logic             clk_Modulation,
  input  logic             reset,
  input  logic             preamble_ready,
  input  logic [5:0]       tx_Rate,
  input  logic [15:0]      packetlength,
  output logic             sig_busy,
  output logic             sig_valid,
  input  logic             sig_ready,
  output logic [OUT_W-1:0] sig_data,
  output logic             sig_last,
  output logic             sig_err
);

  if ((OUT_W == 0) || (OUT_W > SIG_BITS) || ((SIG_BITS % ((OUT_W == 0) ? 1 : OUT_W)) != 0))
  begin : g_bad_out_w
    $error("tx_sig_field_gen: OUT_W must divide 24");
  end
  if ((MAX_LEN < 1) || (MAX_LEN > 4095)) begin : g_bad_max_len
    $error("tx_sig_field_gen: MAX_LEN must be in 1..4095");
  end
  if (SIG_BITS != RATE_BITS + 1 + LEN_BITS + 1 + TAIL_BITS) begin : g_bad_layout
    $error("tx_sig_field_gen: inconsistent L-SIG field widths");
  end

  localparam int unsigned LEN_POS = RATE_BITS + 1;
  localparam int unsigned PAR_POS = LEN_POS + LEN_BITS;
  localparam logic [15:0] MaxLen  = 16'(MAX_LEN);

  typedef enum logic [1:0] {StIdle, StBuild, StSend} state_e;

  state_e        state_q;
  logic [5:0]    rate_q;
  logic [15:0]   len_q;
  logic          busy_q;
  logic          err_q;

  rate_code_t    rc;
  logic          req_ok;
  logic [SIG_BITS-1:0] frame;
  logic          load;
  logic          ser_done;

  always_comb begin
    rc     = sig_rate_code(rate_q);
    req_ok = rc.valid && (len_q != 16'd0) && (len_q <= MaxLen);
    frame  = '0;
    // Rate code is stored R1-first in the MSB; frame bit 0 goes out first.
    frame[RATE_BITS-1:0]        = {rc.code[0], rc.code[1], rc.code[2], rc.code[3]};
    frame[LEN_POS +: LEN_BITS]  = len_q[LEN_BITS-1:0];
    frame[PAR_POS]              = ^frame[PAR_POS-1:0];
  end

  assign load = (state_q == StBuild) && req_ok;

  always_ff @(posedge clk_Modulation) begin
    if (reset) begin
      state_q <= StIdle;
      rate_q  <= '0;
      len_q   <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        StIdle: begin
          // busy_q is still high here only during the error-pulse cycle.
          busy_q <= 1'b0;
          if (preamble_ready && !busy_q) begin
            rate_q  <= tx_Rate;
            len_q   <= packetlength;
            busy_q  <= 1'b1;
            state_q <= StBuild;
          end
        end
        StBuild: begin
          if (req_ok) begin
            state_q <= StSend;
          end else begin
            err_q   <= 1'b1;
            state_q <= StIdle;
          end
        end
        StSend: begin
          if (ser_done) begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  sig_serializer #(
    .WIDTH (SIG_BITS),
    .OUT_W (OUT_W)
  ) u_sig_serializer (
    .clk       (clk_Modulation),
    .reset     (reset),
    .load      (load),
    .load_data (frame),
    .valid     (sig_valid),
    .ready     (sig_ready),
    .data      (sig_data),
    .last      (sig_last),
    .done      (ser_done)
  );

  assign sig_busy = busy_q;
  assign sig_err  = err_q;

endmodule

// File: tb/tb_tx_sig_field_gen.sv
// Drives a 1-bit-wide and a 4-bit-wide generator with shared requests and checks
// both against a frame model built from the L-SIG field rules.
module tb_tx_sig_field_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        preamble_ready;
  logic [5:0]  tx_rate;
  logic [15:0] packetlength;
  logic        sig_ready;

  logic        busy1, valid1, last1, err1;
  logic [0:0]  data1;
  logic        busy4, valid4, last4, err4;
  logic [3:0]  data4;

  int total = 0;
  int bad   = 0;
  logic [23:0] got1, got4;

  always #5 clk = ~clk;

  tx_sig_field_gen #(.OUT_W(1), .MAX_LEN(4095)) u_dut1 (
    .clk_Modulation (clk),
    .reset          (reset),
    .preamble_ready (preamble_ready),
    .tx_Rate        (tx_rate),
    .packetlength   (packetlength),
    .sig_busy       (busy1),
    .sig_valid      (valid1),
    .sig_ready      (sig_ready),
    .sig_data       (data1),
    .sig_last       (last1),
    .sig_err        (err1)
  );

  tx_sig_field_gen #(.OUT_W(4), .MAX_LEN(4095)) u_dut4 (
    .clk_Modulation (clk),
    .reset          (reset),
    .preamble_ready (preamble_ready),
    .tx_Rate        (tx_rate),
    .packetlength   (packetlength),
    .sig_busy       (busy4),
    .sig_valid      (valid4),
    .sig_ready      (sig_ready),
    .sig_data       (data4),
    .sig_last       (last4),
    .sig_err        (err4)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Returns {ok, frame}; frame bit i is transmitted bit t_i.
  function automatic logic [24:0] ref_frame(input int rate, input int len);
    string       code;
    logic [24:0] r;
    int          ones;
    case (rate)
      6:       code = "1101";
      9:       code = "1111";
      12:      code = "0101";
      18:      code = "0111";
      24:      code = "1001";
      36:      code = "1011";
      48:      code = "0001";
      54:      code = "0011";
      default: code = "";
    endcase
    if (code.len() == 0 || len < 1 || len > 4095) return 25'd0;
    r     = '0;
    r[24] = 1'b1;
    for (int i = 0; i < 4; i++) r[i] = (code.getc(i) == "1");
    for (int i = 0; i < 12; i++) r[5 + i] = ((len >> i) & 1) != 0;
    ones = 0;
    for (int i = 0; i < 17; i++) ones += int'(r[i]);
    r[17] = (ones % 2) != 0;
    return r;
  endfunction

  function automatic logic [23:0] str2frame(input string s);
    logic [23:0] f;
    int          idx;
    f   = '0;
    idx = 0;
    for (int i = 0; i < s.len(); i++) begin
      if (s.getc(i) == "1" || s.getc(i) == "0") begin
        f[idx] = (s.getc(i) == "1");
        idx++;
      end
    end
    return f;
  endfunction

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_out1"}, 32'({busy1, valid1, data1, last1, err1}), 32'd0);
    check_eq({tag, "_out4"}, 32'({busy4, valid4, data4, last4, err4}), 32'd0);
  endtask

  // mode: 0 ready held high, 1 ready pattern 1,0,0, 2 random ready.
  task automatic run_req(input int rate, input int len, input int mode, input bit intrude,
                         input int abort_at);
    logic [24:0] m;
    int          k1, k4, cyc;
    bit          done1, done4, r;
    m     = ref_frame(rate, len);
    got1  = '0;
    got4  = '0;
    k1    = 0;
    k4    = 0;
    done1 = 1'b0;
    done4 = 1'b0;
    @(negedge clk);
    tx_rate        = rate[5:0];
    packetlength   = len[15:0];
    preamble_ready = 1'b1;
    @(negedge clk);
    preamble_ready = 1'b0;
    tx_rate        = 6'($urandom);
    packetlength   = 16'($urandom);
    check_eq("build_busy", 32'({busy1, busy4}), 32'd3);
    check_eq("build_quiet", 32'({valid1, valid4, err1, err4}), 32'd0);
    @(negedge clk);
    if (!m[24]) begin
      check_eq("err_pulse", 32'({err1, err4}), 32'd3);
      check_eq("err_no_valid", 32'({valid1, valid4}), 32'd0);
      @(negedge clk);
      check_eq("err_after", 32'({err1, err4, valid1, valid4, busy1, busy4}), 32'd0);
      return;
    end
    cyc = 0;
    while (!(done1 && done4) && cyc < 400) begin
      check_eq("no_err", 32'({err1, err4}), 32'd0);
      if (!done1) begin
        check_eq("w1_valid", 32'(valid1), 32'd1);
        check_eq("w1_data", 32'(data1), 32'(m[k1]));
        check_eq("w1_last", 32'(last1), 32'(k1 == 23));
      end else begin
        check_eq("w1_idle", 32'(valid1), 32'd0);
      end
      if (!done4) begin
        check_eq("w4_valid", 32'(valid4), 32'd1);
        check_eq("w4_data", 32'(data4), 32'(m[k4*4 +: 4]));
        check_eq("w4_last", 32'(last4), 32'(k4 == 5));
      end else begin
        check_eq("w4_idle", 32'(valid4), 32'd0);
      end
      if (abort_at >= 0 && cyc == abort_at) begin
        reset = 1'b1;
        @(negedge clk);
        check_all_zero("abort");
        reset = 1'b0;
        return;
      end
      if (intrude && cyc == 1) begin
        preamble_ready = 1'b1;
        tx_rate        = 6'd6;
        packetlength   = 16'd1;
      end else begin
        preamble_ready = 1'b0;
      end
      case (mode)
        0:       r = 1'b1;
        1:       r = (cyc % 3) == 0;
        default: r = $urandom_range(1, 0) != 0;
      endcase
      sig_ready = r;
      if (r) begin
        if (!done1) begin
          got1[k1] = data1[0];
          k1++;
          done1 = (k1 == 24);
        end
        if (!done4) begin
          got4[k4*4 +: 4] = data4;
          k4++;
          done4 = (k4 == 6);
        end
      end
      @(negedge clk);
      cyc++;
    end
    preamble_ready = 1'b0;
    check_eq("handshakes", 32'({k1[7:0], k4[7:0]}), 32'({8'd24, 8'd6}));
    if (mode == 0) check_eq("w1_cycles", 32'(cyc), 32'd24);
    check_eq("post_frame", 32'({valid1, valid4, last1, last4, busy1, busy4, err1, err4}), 32'd0);
    @(negedge clk);
    check_eq("post_frame2", 32'({valid1, valid4, err1, err4}), 32'd0);
  endtask

  initial begin
    logic [23:0] f54;
    int          rate, len;
    int          rates[8] = '{6, 9, 12, 18, 24, 36, 48, 54};

    reset          = 1'b1;
    preamble_ready = 1'b0;
    sig_ready      = 1'b0;
    tx_rate        = '0;
    packetlength   = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;

    f54 = str2frame("0011 0 001001100000 1 000000");
    run_req(54, 100, 0, 1'b0, -1);
    check_eq("r54_bits_w1", 32'(got1), 32'(f54));
    check_eq("r54_beats_w4", 32'(got4), 32'h0020C8C);
    run_req(6, 1, 0, 1'b0, -1);
    check_eq("r6_bits_w1", 32'(got1), 32'(str2frame("1101 0 100000000000 0 000000")));

    run_req(7, 100, 0, 1'b0, -1);
    run_req(54, 0, 0, 1'b0, -1);
    run_req(54, 4096, 0, 1'b0, -1);

    run_req(54, 100, 1, 1'b0, -1);
    check_eq("stall_beats_w4", 32'(got4), 32'(f54));

    run_req(12, 1234, 0, 1'b1, -1);
    run_req(48, 4095, 2, 1'b0, -1);
    run_req(24, 500, 0, 1'b0, 3);
    run_req(54, 100, 0, 1'b0, -1);
    check_eq("after_abort_w1", 32'(got1), 32'(f54));

    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(7, 0) == 0) rate = int'($urandom_range(63, 0));
      else                           rate = rates[$urandom_range(7, 0)];
      case ($urandom_range(5, 0))
        0:       len = int'($urandom_range(2, 0));
        1:       len = int'($urandom_range(4100, 4090));
        2:       len = int'($urandom_range(65535, 0));
        default: len = int'($urandom_range(4095, 1));
      endcase
      run_req(rate, len, int'($urandom_range(2, 0)), 1'b0, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tx_sig_field_gen.md
Name: tx_sig_field_gen

Overview:
- Parametrised next-generation 802.11a SIGNAL-field generator.
- Builds the 24-bit L-SIG from a rate code and a PSDU length:
  - RATE(4), reserved(1), LENGTH(12, LSB first), even parity(1), tail(6).
- Streams the field OUT_W bits per beat to the convolutional encoder over a valid/ready handshake.
- Adds request validation with an error pulse, a busy indication, downstream backpressure and a last-beat marker.

Parameters:
- OUT_W, 1, bits per output beat; legal values 1,2,3,4,6,8,12,24 (must divide 24); any other value is an elaboration error.
- MAX_LEN, 4095, largest accepted packetlength in bytes; legal range 1..4095.

Ports:
- clk_Modulation  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- preamble_ready  in  1  single-cycle request strobe; samples tx_Rate and packetlength.
- tx_Rate  in  6  rate in Mbps; legal values 6,9,12,18,24,36,48,54.
- packetlength  in  16  PSDU length in bytes.
- sig_busy  out  1  high from the cycle after an accepted request until the cycle after the last beat/err.
- sig_valid  out  1  output beat valid.
- sig_ready  in  1  downstream accepts the beat.
- sig_data  out  OUT_W  beat; bit 0 is the earliest-transmitted bit.
- sig_last  out  1  high with the final beat.
- sig_err  out  1  one-cycle pulse on a rejected request.

Behaviour:
- Reset: every output is 0, FSM in IDLE, shift register and beat counter cleared. Reset during BUILD or SEND aborts immediately with no partial beats afterwards.
- FSM states:
  - IDLE: preamble_ready=1 latches tx_Rate and packetlength, then goes to BUILD. preamble_ready outside IDLE is ignored.
  - BUILD, one cycle:
    - Map rate to R1..R4 in transmit order: 6→1101, 9→1111, 12→0101, 18→0111, 24→1001, 36→1011, 48→0001, 54→0011.
    - Invalid rate, packetlength==0, or packetlength>MAX_LEN: sig_err=1 for one cycle, return to IDLE, no beats.
    - Otherwise load the 24-bit frame in transmit order: t0..t3=R1..R4, t4=0, t5..t16=length[0..11], t17=parity, t18..t23=0. Go to SEND.
  - SEND: sig_valid=1 and sig_data = the next OUT_W frame bits.
    - On sig_valid && sig_ready, shift by OUT_W and increment the beat counter.
    - The beat with counter == 24/OUT_W−1 asserts sig_last. Its acceptance returns the FSM to IDLE with sig_valid=0 on the next cycle.
- Parity: XOR of t0..t16, so that t0..t17 have even weight.
- Latency: preamble_ready at cycle N gives sig_valid or sig_err at N+2. Back-to-back requests are accepted one cycle after sig_busy falls.
- Backpressure: while sig_valid=1 and sig_ready=0, sig_data and sig_last hold stable and the counter holds. Unbounded stalls are allowed.
- All outputs are registered.
- packetlength[15:12] is ignored except for the >MAX_LEN check.

Decomposition:
- Shared package ofdm_tx_pkg:
  - L-SIG field widths (SIG_BITS=24, RATE_BITS=4, LEN_BITS=12, TAIL_BITS=6).
  - The rate→R1..R4 constant table.
  - A function sig_rate_code(rate) returning code plus a valid flag.
- One natural sub-module: sig_serializer. This is the generic parallel-in, OUT_W-wide valid/ready shifter with beat counter and last flag, reusable for the HT-SIG later.
- The FSM, validation and frame assembly stay in tx_sig_field_gen.

Test Plan:
- OUT_W=1, rate 54, length 100, sig_ready=1 held.
  - Serial bits: 0011 0 001001100000 1 000000.
  - sig_valid at N+2 for 24 cycles, sig_last on cycle 24.
- OUT_W=4, same request → beats 0xC, 0x8, 0xC, 0x0, 0x2, 0x0, with sig_last on 0x0 (beat 6).
- OUT_W=1, rate 6, length 1 → 1101 0 100000000000 0 000000 (parity 0).
- Rate 7, length 100 → sig_err pulse at N+2, no sig_valid. Length 0 or 4096 gives the same result.
- OUT_W=4, sig_ready toggled 1,0,0,1… → each beat is held stable while stalled, the sequence is unchanged, and exactly 6 handshakes complete.
- preamble_ready pulsed during SEND → ignored and frame unchanged. Reset asserted mid-SEND → all outputs 0 next cycle, and a new request afterwards yields a correct full frame.
